// File: rtl/register_file_sb.sv
// Register file with two registered read ports, one write-back port and a
// pending-write scoreboard that stalls reads of reserved registers.
module register_file_sb #(
    parameter int unsigned W        = 16,
    parameter int unsigned DEPTH    = 4,
    parameter bit          ZERO_REG = 1'b0,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [W-1:0]     wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr_1,
    input  logic [AW-1:0]    rd_addr_2,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_addr,
    output logic [W-1:0]     rd_data_1,
    output logic [W-1:0]     rd_data_2,
    output logic             rd_valid,
    output logic             stall,
    output logic [DEPTH-1:0] pending,
    output logic             rsv_conflict
);

    logic [W-1:0]     regs_q [DEPTH];
    logic [W-1:0]     regs_d [DEPTH];
    logic [DEPTH-1:0] pending_q, pending_d;
    logic [W-1:0]     rd_data_1_q, rd_data_1_d;
    logic [W-1:0]     rd_data_2_q, rd_data_2_d;
    logic             rd_valid_q, rd_valid_d;
    logic             rsv_conflict_q, rsv_conflict_d;

    logic wr_eff;
    logic rsv_eff;
    logic hazard_1;
    logic hazard_2;
    logic accept;
    logic [W-1:0] src_1;
    logic [W-1:0] src_2;

    // Writes and reserves aimed at a hardwired zero register are dropped.
    always_comb begin
        wr_eff  = wr_en;
        rsv_eff = rsv_en;
        if (ZERO_REG && (wr_addr == '0)) begin
            wr_eff = 1'b0;
        end
        if (ZERO_REG && (rsv_addr == '0)) begin
            rsv_eff = 1'b0;
        end
    end

    // A write landing this cycle resolves the hazard on its destination.
    always_comb begin
        hazard_1 = pending_q[rd_addr_1] && !(wr_en && (wr_addr == rd_addr_1));
        hazard_2 = pending_q[rd_addr_2] && !(wr_en && (wr_addr == rd_addr_2));
        stall    = rd_en && (hazard_1 || hazard_2);
        accept   = rd_en && !stall;
    end

    always_comb begin
        if (ZERO_REG && (rd_addr_1 == '0)) begin
            src_1 = '0;
        end else if (wr_en && (wr_addr == rd_addr_1)) begin
            src_1 = wr_data;
        end else begin
            src_1 = regs_q[rd_addr_1];
        end

        if (ZERO_REG && (rd_addr_2 == '0)) begin
            src_2 = '0;
        end else if (wr_en && (wr_addr == rd_addr_2)) begin
            src_2 = wr_data;
        end else begin
            src_2 = regs_q[rd_addr_2];
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_eff) begin
            regs_d[wr_addr] = wr_data;
        end

        // Clear on write-back first so a same-edge reserve wins.
        pending_d = pending_q;
        if (wr_eff) begin
            pending_d[wr_addr] = 1'b0;
        end
        if (rsv_eff) begin
            pending_d[rsv_addr] = 1'b1;
        end
        if (ZERO_REG) begin
            pending_d[0] = 1'b0;
        end

        rsv_conflict_d = rsv_eff && pending_q[rsv_addr] && !(wr_eff && (wr_addr == rsv_addr));

        rd_valid_d  = accept;
        rd_data_1_d = rd_data_1_q;
        rd_data_2_d = rd_data_2_q;
        if (accept) begin
            rd_data_1_d = src_1;
            rd_data_2_d = src_2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            pending_q      <= '0;
            rd_data_1_q    <= '0;
            rd_data_2_q    <= '0;
            rd_valid_q     <= 1'b0;
            rsv_conflict_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            pending_q      <= pending_d;
            rd_data_1_q    <= rd_data_1_d;
            rd_data_2_q    <= rd_data_2_d;
            rd_valid_q     <= rd_valid_d;
            rsv_conflict_q <= rsv_conflict_d;
        end
    end

    assign rd_data_1    = rd_data_1_q;
    assign rd_data_2    = rd_data_2_q;
    assign rd_valid     = rd_valid_q;
    assign pending      = pending_q;
    assign rsv_conflict = rsv_conflict_q;

endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench for register_file_sb: one instance with a writable register 0
// and one with register 0 hardwired to zero, driven by the same stimulus.
module tb_register_file_sb;

    localparam int unsigned W     = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [W-1:0]     wr_data;
    logic             rd_en;
    logic [AW-1:0]    rd_addr_1;
    logic [AW-1:0]    rd_addr_2;
    logic             rsv_en;
    logic [AW-1:0]    rsv_addr;

    logic [W-1:0]     rd_data_1, rd_data_2;
    logic             rd_valid, stall, rsv_conflict;
    logic [DEPTH-1:0] pending;

    logic [W-1:0]     z_rd_data_1, z_rd_data_2;
    logic             z_rd_valid, z_stall, z_rsv_conflict;
    logic [DEPTH-1:0] z_pending;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    register_file_sb #(.W(W), .DEPTH(DEPTH), .ZERO_REG(1'b0)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_addr_1    (rd_addr_1),
        .rd_addr_2    (rd_addr_2),
        .rsv_en       (rsv_en),
        .rsv_addr     (rsv_addr),
        .rd_data_1    (rd_data_1),
        .rd_data_2    (rd_data_2),
        .rd_valid     (rd_valid),
        .stall        (stall),
        .pending      (pending),
        .rsv_conflict (rsv_conflict)
    );

    register_file_sb #(.W(W), .DEPTH(DEPTH), .ZERO_REG(1'b1)) u_dut_zero (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_addr_1    (rd_addr_1),
        .rd_addr_2    (rd_addr_2),
        .rsv_en       (rsv_en),
        .rsv_addr     (rsv_addr),
        .rd_data_1    (z_rd_data_1),
        .rd_data_2    (z_rd_data_2),
        .rd_valid     (z_rd_valid),
        .stall        (z_stall),
        .pending      (z_pending),
        .rsv_conflict (z_rsv_conflict)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst       = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_en     = 1'b0;
        rd_addr_1 = '0;
        rd_addr_2 = '0;
        rsv_en    = 1'b0;
        rsv_addr  = '0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
    endtask

    task automatic do_read(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        rd_en     = 1'b1;
        rd_addr_1 = a1;
        rd_addr_2 = a2;
    endtask

    task automatic do_rsv(input logic [AW-1:0] a);
        rsv_en   = 1'b1;
        rsv_addr = a;
    endtask

    // Advance one edge and settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();

        check_eq("reset_pending", 32'(pending), 32'h0);
        check_eq("reset_valid", 32'(rd_valid), 32'h0);
        check_eq("reset_data1", 32'(rd_data_1), 32'h0);
        check_eq("reset_conflict", 32'(rsv_conflict), 32'h0);

        // Read after reset
        idle();
        do_read(2'd1, 2'd2);
        #1;
        check_eq("rd12_stall", 32'(stall), 32'h0);
        tick();
        check_eq("rd12_valid", 32'(rd_valid), 32'h1);
        check_eq("rd12_data1", 32'(rd_data_1), 32'h0);
        check_eq("rd12_data2", 32'(rd_data_2), 32'h0);
        check_eq("rd12_pending", 32'(pending), 32'h0);

        // Write then read; then bypass on a same-cycle write
        idle();
        do_write(2'd2, 16'hEAAE);
        tick();
        check_eq("wr2_valid_drop", 32'(rd_valid), 32'h0);
        check_eq("wr2_data_hold", 32'(rd_data_1), 32'h0);
        idle();
        do_read(2'd2, 2'd2);
        tick();
        check_eq("rd22_data1", 32'(rd_data_1), 32'hEAAE);
        check_eq("rd22_data2", 32'(rd_data_2), 32'hEAAE);
        idle();
        do_write(2'd1, 16'hABCD);
        do_read(2'd1, 2'd3);
        tick();
        check_eq("bypass_data1", 32'(rd_data_1), 32'hABCD);
        check_eq("bypass_data2", 32'(rd_data_2), 32'h0);
        check_eq("b2b_valid", 32'(rd_valid), 32'h1);

        // Reserve 3, stalled read until the write-back lands
        idle();
        do_rsv(2'd3);
        tick();
        check_eq("rsv3_pending", 32'(pending), 32'h8);
        check_eq("no_rd_no_stall", 32'(stall), 32'h0);
        idle();
        do_read(2'd3, 2'd0);
        #1;
        check_eq("rd3_stall", 32'(stall), 32'h1);
        tick();
        check_eq("stall_valid", 32'(rd_valid), 32'h0);
        check_eq("stall_hold1", 32'(rd_data_1), 32'hABCD);
        check_eq("stall_hold2", 32'(rd_data_2), 32'h0);
        check_eq("stall2_stall", 32'(stall), 32'h1);
        tick();
        check_eq("stall2_valid", 32'(rd_valid), 32'h0);
        do_write(2'd3, 16'h0935);
        #1;
        check_eq("wb3_stall", 32'(stall), 32'h0);
        tick();
        check_eq("wb3_data1", 32'(rd_data_1), 32'h0935);
        check_eq("wb3_data2", 32'(rd_data_2), 32'h0);
        check_eq("wb3_valid", 32'(rd_valid), 32'h1);
        check_eq("wb3_pending", 32'(pending), 32'h0);

        // Double reserve conflict, and write+reserve on the same edge
        idle();
        do_rsv(2'd1);
        tick();
        check_eq("rsv1_pending", 32'(pending), 32'h2);
        check_eq("rsv1_conflict", 32'(rsv_conflict), 32'h0);
        tick();
        check_eq("rsv1x2_conflict", 32'(rsv_conflict), 32'h1);
        check_eq("rsv1x2_pending", 32'(pending), 32'h2);
        idle();
        do_rsv(2'd2);
        tick();
        check_eq("conflict_pulse_end", 32'(rsv_conflict), 32'h0);
        check_eq("rsv2_pending", 32'(pending), 32'h6);
        idle();
        do_write(2'd2, 16'h1111);
        do_rsv(2'd2);
        tick();
        check_eq("wrrsv2_pending", 32'(pending), 32'h6);
        check_eq("wrrsv2_conflict", 32'(rsv_conflict), 32'h0);

        // Reset with every strobe active; reservations on 1 and 2 are discarded
        idle();
        rst = 1'b1;
        do_write(2'd3, 16'h1234);
        do_read(2'd3, 2'd2);
        do_rsv(2'd3);
        tick();
        check_eq("rst_pending", 32'(pending), 32'h0);
        check_eq("rst_valid", 32'(rd_valid), 32'h0);
        check_eq("rst_data1", 32'(rd_data_1), 32'h0);
        check_eq("rst_data2", 32'(rd_data_2), 32'h0);
        check_eq("rst_conflict", 32'(rsv_conflict), 32'h0);
        idle();
        do_read(2'd1, 2'd3);
        #1;
        check_eq("postrst_stall", 32'(stall), 32'h0);
        tick();
        check_eq("postrst_valid", 32'(rd_valid), 32'h1);
        check_eq("postrst_data1", 32'(rd_data_1), 32'h0);
        check_eq("postrst_data2", 32'(rd_data_2), 32'h0);
        idle();
        do_write(2'd1, 16'h5555);
        tick();
        check_eq("late_wb_pending", 32'(pending), 32'h0);
        idle();
        do_read(2'd1, 2'd1);
        tick();
        check_eq("late_wb_data", 32'(rd_data_1), 32'h5555);

        // Hardwired register 0 (u_dut_zero); u_dut sees register 0 as ordinary
        idle();
        do_write(2'd0, 16'hFFFF);
        tick();
        check_eq("z_wr0_pending", 32'(z_pending), 32'h0);
        idle();
        do_rsv(2'd0);
        tick();
        check_eq("z_rsv0_pending", 32'(z_pending), 32'h0);
        check_eq("rsv0_pending", 32'(pending), 32'h1);
        do_read(2'd0, 2'd0);
        #1;
        check_eq("z_rd0_stall", 32'(z_stall), 32'h0);
        check_eq("rd0_stall", 32'(stall), 32'h1);
        tick();
        check_eq("z_rd0_valid", 32'(z_rd_valid), 32'h1);
        check_eq("z_rd0_data1", 32'(z_rd_data_1), 32'h0);
        check_eq("z_rd0_data2", 32'(z_rd_data_2), 32'h0);
        check_eq("z_rsv0_conflict", 32'(z_rsv_conflict), 32'h0);
        check_eq("rsv0_conflict", 32'(rsv_conflict), 32'h1);
        idle();
        do_write(2'd0, 16'hFFFF);
        do_read(2'd0, 2'd1);
        tick();
        check_eq("z_bypass0_data1", 32'(z_rd_data_1), 32'h0);
        check_eq("z_bypass0_data2", 32'(z_rd_data_2), 32'h5555);
        check_eq("bypass0_data1", 32'(rd_data_1), 32'hFFFF);
        check_eq("bypass0_pending", 32'(pending), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/register_file_sb.md
REGISTER_FILE_SB -- requirements
Module: register_file_sb

Interface
REQ-001 SHALL have parameter W, default 16: data width in bits (W >= 1).
REQ-002 SHALL have parameter DEPTH, default 4: register count (power of two, >= 2); AW = clog2(DEPTH), derived.
REQ-003 SHALL have parameter ZERO_REG, default 0: when 1, register 0 is hardwired to zero.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port wr_en  input  1  write-back strobe.
REQ-007 SHALL have port wr_addr  input  AW  write-back destination.
REQ-008 SHALL have port wr_data  input  W  write-back data.
REQ-009 SHALL have port rd_en  input  1  read request for both sources.
REQ-010 SHALL have port rd_addr_1  input  AW  source 1 address.
REQ-011 SHALL have port rd_addr_2  input  AW  source 2 address.
REQ-012 SHALL have port rsv_en  input  1  reserve a destination (mark it pending).
REQ-013 SHALL have port rsv_addr  input  AW  destination to reserve.
REQ-014 SHALL have port rd_data_1  output  W  registered source 1 data.
REQ-015 SHALL have port rd_data_2  output  W  registered source 2 data.
REQ-016 SHALL have port rd_valid  output  1  rd_data_1/2 hold the result of an accepted read.
REQ-017 SHALL have port stall  output  1  combinational; read request refused this cycle.
REQ-018 SHALL have port pending  output  DEPTH  scoreboard, bit i = register i awaiting write-back.
REQ-019 SHALL have port rsv_conflict  output  1  one-cycle pulse: reserve hit an already-pending register.

Function
REQ-020 Write: on an edge with wr_en=1, reg[wr_addr] <= wr_data; no other register changes.
REQ-021 Scoreboard: on an edge, wr_en=1 clears pending[wr_addr]; rsv_en=1 sets pending[rsv_addr]; when both target the same address on one edge, pending ends 1 (reserve wins).
REQ-022 Stall: stall=1 iff rd_en=1 and either source address has pending=1 and is not being written this cycle (wr_en=1 with wr_addr equal to that source clears the hazard).
REQ-023 Accept: a read is accepted when rd_en=1 and stall=0; rd_data_1/2 update on that edge, giving 1-cycle latency.
REQ-024 Bypass: on an accepted read whose source equals wr_addr while wr_en=1, that rd_data takes wr_data, not the old contents.
REQ-025 rd_valid SHALL be 1 in the cycle after an accepted read, else 0; when not accepted, rd_data_1/2 hold their previous values.
REQ-026 Back-to-back accepted reads SHALL be sustained every cycle with no bubble.
REQ-027 rsv_conflict SHALL pulse 1 in the cycle after an edge with rsv_en=1 where pending[rsv_addr] was 1 and was not cleared by write on that edge; pending stays 1.
REQ-028 ZERO_REG=1: reads of address 0 return 0 (also on bypass), writes to 0 are ignored, reserve of 0 is ignored, pending[0] is constantly 0, and address 0 never stalls.
REQ-029 Reads, writes and reserves to any address in one cycle are all legal and processed concurrently per REQ-020..REQ-028.

Reset
REQ-030 On an edge with rst=1: all registers, pending, rd_data_1/2, rd_valid and rsv_conflict SHALL become 0, overriding wr_en, rd_en and rsv_en on that edge.
REQ-031 Reset mid-operation SHALL discard outstanding reservations; a write-back arriving after reset SHALL still update the register and clear an already-clear pending bit harmlessly.

Verification (W=16, DEPTH=4 unless stated)
REQ-032 Reset then read addresses 1,2 -> next cycle rd_valid=1, rd_data_1=rd_data_2=0x0000, pending=4'b0000.
REQ-033 Write 0xEAAE to reg 2, next cycle read 2,2 -> rd_data_1=rd_data_2=0xEAAE; same-cycle write 0xABCD to reg 1 plus read 1,3 -> rd_data_1=0xABCD (bypass).
REQ-034 Reserve reg 3, then read 3,0 -> stall=1, rd_valid=0 and rd_data unchanged until wr_en to reg 3 with 0x0935; on that cycle stall=0, next cycle rd_data_1=0x0935, pending[3]=0.
REQ-035 Reserve reg 1 twice with no write in between -> rsv_conflict pulses for one cycle, pending=4'b0010; same-cycle write+reserve of reg 2 -> pending[2]=1, no conflict pulse.
REQ-036 ZERO_REG=1: write 0xFFFF to reg 0, reserve reg 0, read 0,0 -> stall=0, rd_data_1=rd_data_2=0x0000, pending[0]=0.
REQ-037 Reserve regs 1 and 2, assert rst for one cycle -> pending=4'b0000, all outputs 0; subsequent read of 1 does not stall.
